// File: rtl/pwm_bank.sv
// Prescaled period counter driving CHANNELS PWM outputs from double-buffered channel settings.
// pwm_o is registered one cycle behind counter_o; no backpressure, one write accepted every cycle.
module pwm_bank #(
   parameter int CHANNELS   = 16,
   parameter int CNT_W      = 12,
   parameter int PRESCALE_W = 8,
   parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [PRESCALE_W-1:0] prescale_i,
   input  logic                  sleep_i,
   input  logic                  invert_i,
   input  logic                  update_mode_i,
   input  logic                  wr_en_i,
   input  logic [CH_W-1:0]       wr_ch_i,
   input  logic [CNT_W-1:0]      wr_on_i,
   input  logic [CNT_W-1:0]      wr_off_i,
   input  logic                  wr_full_on_i,
   input  logic                  wr_full_off_i,
   output logic [CNT_W-1:0]      counter_o,
   output logic                  period_start_o,
   output logic                  pending_o,
   output logic [CHANNELS-1:0]   pwm_o
);

   logic [PRESCALE_W-1:0] pre_cnt;
   logic                  tick;
   logic                  wrap;
   logic                  commit_en;
   logic                  wr_ok;
   logic [CHANNELS-1:0]   pend;
   logic [CHANNELS-1:0]   level;

   // >= rather than == so lowering prescale_i below pre_cnt ticks immediately
   assign tick      = !sleep_i && (pre_cnt >= prescale_i);
   assign wrap      = tick && (&counter_o);
   assign commit_en = !sleep_i && (update_mode_i || wrap);
   assign wr_ok     = wr_en_i && ({1'b0, wr_ch_i} < (CH_W + 1)'(CHANNELS));
   assign pending_o = |pend;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_cnt        <= '0;
         counter_o      <= '0;
         period_start_o <= 1'b0;
      end else begin
         period_start_o <= wrap;
         if (sleep_i || tick) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
         if (sleep_i) begin
            counter_o <= '0;
         end else if (tick) begin
            counter_o <= counter_o + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [CNT_W-1:0] sh_on, sh_off, act_on, act_off;
      logic             sh_fon, sh_foff, act_fon, act_foff;
      logic             pend_q, sel, commit, lvl;

      assign sel     = wr_ok && (wr_ch_i == CH_W'(g));
      assign commit  = commit_en && pend_q;
      assign pend[g] = pend_q;
      assign level[g] = lvl;

      // A write landing on a commit edge: active takes the old shadow, pending stays set
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            sh_on    <= '0;
            sh_off   <= '0;
            sh_fon   <= 1'b0;
            sh_foff  <= 1'b1;
            act_on   <= '0;
            act_off  <= '0;
            act_fon  <= 1'b0;
            act_foff <= 1'b1;
            pend_q   <= 1'b0;
         end else begin
            if (commit) begin
               act_on   <= sh_on;
               act_off  <= sh_off;
               act_fon  <= sh_fon;
               act_foff <= sh_foff;
            end
            if (sel) begin
               sh_on   <= wr_on_i;
               sh_off  <= wr_off_i;
               sh_fon  <= wr_full_on_i;
               sh_foff <= wr_full_off_i;
            end
            if (sel) begin
               pend_q <= 1'b1;
            end else if (commit) begin
               pend_q <= 1'b0;
            end
         end
      end

      always_comb begin
         lvl = 1'b0;
         if (act_foff) begin
            lvl = 1'b0;
         end else if (act_fon) begin
            lvl = 1'b1;
         end else if (act_on == act_off) begin
            lvl = 1'b0;
         end else if (act_on < act_off) begin
            lvl = (counter_o >= act_on) && (counter_o < act_off);
         end else begin
            lvl = (counter_o >= act_on) || (counter_o < act_off);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pwm_o <= '0;
      end else if (sleep_i) begin
         pwm_o <= {CHANNELS{invert_i}};
      end else begin
         pwm_o <= level ^ {CHANNELS{invert_i}};
      end
   end

endmodule
